// File: rtl/cpu_pkg.sv
// Shared RV32I definitions: opcodes, inst_class bit positions and the decoded
// instruction record passed from the decoder into the instruction queue.
package cpu_pkg;

    localparam int PC_MAX_W = 64;
    localparam int CLASS_W  = 11;
    localparam int MOD_W    = 10;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam int CLS_LUI      = 0;
    localparam int CLS_AUIPC    = 1;
    localparam int CLS_JAL      = 2;
    localparam int CLS_JALR     = 3;
    localparam int CLS_BRANCH   = 4;
    localparam int CLS_LOAD     = 5;
    localparam int CLS_STORE    = 6;
    localparam int CLS_OP_IMM   = 7;
    localparam int CLS_OP       = 8;
    localparam int CLS_MISC_MEM = 9;
    localparam int CLS_SYSTEM   = 10;

    // pc is sized for the widest supported PC; narrower users zero-extend it.
    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [MOD_W-1:0]    mod;
        logic signed [31:0]  imm;
        logic [CLASS_W-1:0]  cls;
        logic                illegal;
    } inst_rec_t;

endpackage

// File: rtl/cpu_inst_decoder.sv
// Combinational RV32I decoder: raw instruction word plus PC to a decoded record.
module cpu_inst_decoder
    import cpu_pkg::*;
#(
    parameter int PC_W          = 32,
    parameter bit CHECK_ILLEGAL = 1'b1
) (
    input  logic [31:0]   inst,
    input  logic [PC_W-1:0] pc,
    output inst_rec_t     rec
);

    function automatic logic signed [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'b0};
    endfunction

    function automatic logic signed [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        rec          = '0;
        rec.pc       = PC_MAX_W'(pc);
        rec.rd       = inst[11:7];
        rec.rs1      = inst[19:15];
        rec.rs2      = inst[24:20];
        rec.mod[2:0] = funct3;
        case (opcode)
            OPC_LUI: begin
                rec.cls[CLS_LUI] = 1'b1;
                rec.imm          = imm_u(inst);
            end
            OPC_AUIPC: begin
                rec.cls[CLS_AUIPC] = 1'b1;
                rec.imm            = imm_u(inst);
            end
            OPC_JAL: begin
                rec.cls[CLS_JAL] = 1'b1;
                rec.imm          = imm_j(inst);
            end
            OPC_JALR: begin
                rec.cls[CLS_JALR] = 1'b1;
                rec.imm           = imm_i(inst);
            end
            OPC_BRANCH: begin
                rec.cls[CLS_BRANCH] = 1'b1;
                rec.imm             = imm_b(inst);
            end
            OPC_LOAD: begin
                rec.cls[CLS_LOAD] = 1'b1;
                rec.imm           = imm_i(inst);
            end
            OPC_STORE: begin
                rec.cls[CLS_STORE] = 1'b1;
                rec.imm            = imm_s(inst);
            end
            OPC_OP_IMM: begin
                rec.cls[CLS_OP_IMM] = 1'b1;
                rec.imm             = imm_i(inst);
                // Only the shifts carry a funct7 (arith/logical select).
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    rec.mod[9:3] = funct7;
            end
            OPC_OP: begin
                rec.cls[CLS_OP] = 1'b1;
                rec.mod[9:3]    = funct7;
            end
            OPC_MISC_MEM: rec.cls[CLS_MISC_MEM] = 1'b1;
            OPC_SYSTEM:   rec.cls[CLS_SYSTEM]   = 1'b1;
            default:      rec.illegal           = CHECK_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_inst_queue.sv
// DEPTH-entry instruction FIFO between fetch and execute; words are decoded on
// enqueue and the head record is presented on a valid/ready interface.
module cpu_inst_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int PC_W          = 32,
    parameter bit CHECK_ILLEGAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [4:0]               rd,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [9:0]               mod,
    output logic [31:0]              imm,
    output logic [10:0]              inst_class,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    inst_rec_t        dec_rec;
    inst_rec_t        mem [DEPTH];
    inst_rec_t        head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    cpu_inst_decoder #(
        .PC_W          (PC_W),
        .CHECK_ILLEGAL (CHECK_ILLEGAL)
    ) u_dec (
        .inst (in_inst),
        .pc   (in_pc),
        .rec  (dec_rec)
    );

    assign out_valid = (count != '0);
    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready  = (count < CNT_W'(DEPTH)) || out_ready;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Storage is data only; validity comes from count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= dec_rec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty queue shows all-zero fields rather than a stale entry.
    always_comb begin
        head = '0;
        if (out_valid)
            head = mem[rd_ptr];
    end

    assign out_pc     = head.pc[PC_W-1:0];
    assign rd         = head.rd;
    assign rs1        = head.rs1;
    assign rs2        = head.rs2;
    assign mod        = head.mod;
    assign imm        = head.imm;
    assign inst_class = head.cls;
    assign illegal    = head.illegal;

endmodule

// File: tb/tb_cpu_inst_queue.sv
// Directed bench for cpu_inst_queue; a second instance with CHECK_ILLEGAL = 0
// shares the stimulus to cover the untied illegal flag.
module tb_cpu_inst_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  u2_in_ready;
    logic        out_valid, u2_out_valid;
    logic [31:0] out_pc,    u2_out_pc;
    logic [4:0]  rd, rs1, rs2, u2_rd, u2_rs1, u2_rs2;
    logic [9:0]  mod,       u2_mod;
    logic [31:0] imm,       u2_imm;
    logic [10:0] inst_class, u2_inst_class;
    logic        illegal,   u2_illegal;
    logic [2:0]  count,     u2_count;

    int total = 0;
    int bad   = 0;

    cpu_inst_queue #(.DEPTH(4), .PC_W(32), .CHECK_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2),
        .mod(mod), .imm(imm), .inst_class(inst_class), .illegal(illegal),
        .count(count)
    );

    cpu_inst_queue #(.DEPTH(4), .PC_W(32), .CHECK_ILLEGAL(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u2_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(u2_out_valid),
        .out_ready(out_ready), .out_pc(u2_out_pc), .rd(u2_rd), .rs1(u2_rs1),
        .rs2(u2_rs2), .mod(u2_mod), .imm(u2_imm), .inst_class(u2_inst_class),
        .illegal(u2_illegal), .count(u2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p, input logic r);
        in_valid  = v;
        in_inst   = w;
        in_pc     = p;
        out_ready = r;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #3;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_imm", imm, 0);
        chk("rst_class", inst_class, 0);
        chk("rst_illegal", illegal, 0);
        #9 rst_n = 1'b1;
        step();

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'h100, 1'b0);
        step();
        chk("addi_valid", out_valid, 1);
        chk("addi_class", inst_class, 11'h080);
        chk("addi_rd", rd, 1);
        chk("addi_rs1", rs1, 0);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_mod", mod, 0);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_count", count, 1);
        chk("addi_illegal", illegal, 0);

        // srai x2,x2,3 with pop of addi
        drive(1'b1, 32'h40315113, 32'h104, 1'b1);
        step();
        chk("srai_mod", mod, 10'h105);
        chk("srai_imm", imm, 32'h00000403);
        chk("srai_rd", rd, 2);
        chk("srai_rs2", rs2, 3);
        chk("srai_count", count, 1);

        // jal x1,-4
        drive(1'b1, 32'hFFDFF0EF, 32'h108, 1'b1);
        step();
        chk("jal_class", inst_class, 11'h004);
        chk("jal_imm", imm, 32'hFFFFFFFC);
        chk("jal_rd", rd, 1);

        // sw x2,8(x1)
        drive(1'b1, 32'h0020A423, 32'h10C, 1'b1);
        step();
        chk("sw_class", inst_class, 11'h040);
        chk("sw_imm", imm, 32'h8);
        chk("sw_mod", mod, 10'h002);

        // beq x1,x2,-8
        drive(1'b1, 32'hFE208CE3, 32'h110, 1'b1);
        step();
        chk("beq_class", inst_class, 11'h010);
        chk("beq_imm", imm, 32'hFFFFFFF8);
        chk("beq_pc", out_pc, 32'h110);

        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk("drain_count", count, 0);
        chk("drain_valid", out_valid, 0);
        chk("drain_imm", imm, 0);

        // Fill with five offered words while the consumer stalls.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h00000013 | (32'(i) << 20), 32'h200 + 32'(4 * i), 1'b0);
            step();
        end
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_head_pc", out_pc, 32'h200);
        chk("full_head_imm", imm, 0);

        drive(1'b1, 32'h00900013, 32'h214, 1'b1);
        #1;
        chk("full_in_ready_pop", in_ready, 1);
        step();
        chk("full_pp_count", count, 4);
        chk("full_pp_head", out_pc, 32'h204);

        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("order0", out_pc, 32'h204);
        step();
        chk("order1", out_pc, 32'h208);
        step();
        chk("order2", out_pc, 32'h20C);
        step();
        chk("order3", out_pc, 32'h214);
        chk("order3_imm", imm, 9);
        step();
        chk("order_empty", count, 0);

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00100093, 32'h300 + 32'(4 * i), 1'b0);
            step();
        end
        chk("pre_flush_count", count, 3);
        drive(1'b1, 32'h00100093, 32'h30C, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_pc", out_pc, 0);
        chk("flush_rd", rd, 0);
        chk("flush_imm", imm, 0);
        chk("flush_class", inst_class, 0);
        step();
        chk("flush_lost", count, 0);

        // Unknown opcode.
        drive(1'b1, 32'h00000000, 32'h400, 1'b0);
        step();
        chk("ill_flag", illegal, 1);
        chk("ill_class", inst_class, 0);
        chk("ill_pc", out_pc, 32'h400);
        chk("ill_nochk_valid", u2_out_valid, 1);
        chk("ill_nochk_flag", u2_illegal, 0);
        chk("ill_nochk_class", u2_inst_class, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk("ill_drain", count, 0);

        // Asynchronous reset mid-operation.
        drive(1'b1, 32'h00500013, 32'h600, 1'b0);
        step();
        drive(1'b1, 32'h00600013, 32'h604, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("pre_rst_count", count, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_imm", imm, 0);
        chk("arst_in_ready", in_ready, 1);
        #1 rst_n = 1'b1;

        // Wrap pointers twice through streaming push+pop.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h00000013 | (32'(i + 16) << 20), 32'h500 + 32'(4 * i), 1'b1);
            step();
            chk($sformatf("wrap_pc%0d", i), out_pc, 32'h500 + 32'(4 * i));
            chk($sformatf("wrap_imm%0d", i), imm, 32'(i + 16));
            chk($sformatf("wrap_cnt%0d", i), count, 1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk("wrap_empty", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
